gf_const_mult_column_seq: RTL

// Sequential, parametrised GF(2^M) constant-multiplier column for the BCH Euclidean/Chien datapath.

---
 rtl/gf_pkg.sv | 52 +++++
 rtl/gf_const_mult_column_seq_if.sv | 26 ++
 rtl/gf_const_mul.sv | 15 +
 rtl/gf_const_mult_column_seq.sv | 91 +++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^m) helpers: the FSM state type and elaboration-time constant arithmetic
// used to build fixed-constant multipliers as pure XOR networks.
package gf_pkg;

  localparam int unsigned GF_M    = 13;
  localparam logic [31:0] GF_POLY = 32'h0000_001B;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } col_state_e;

  function automatic logic [31:0] gf_mask(input int unsigned m);
    return (m >= 32) ? 32'hFFFF_FFFF : ((32'h1 << m) - 32'h1);
  endfunction

  // Multiply by alpha: shift left, fold the overflowing x^m term back through POLY.
  function automatic logic [31:0] gf_xtime(input logic [31:0] x, input int unsigned m,
                                           input logic [31:0] poly);
    logic [31:0] r;
    r = (x << 1) & gf_mask(m);
    if (((x >> (m - 1)) & 32'h1) != 32'h0) r = r ^ (poly & gf_mask(m));
    return r;
  endfunction

  function automatic logic [31:0] gf_alpha_pow(input int unsigned e, input int unsigned m,
                                               input logic [31:0] poly);
    logic [31:0] r;
    int unsigned order;
    int unsigned ee;
    order = gf_mask(m);
    ee    = (order == 0) ? 0 : (e % order);
    r     = 32'h1;
    for (int unsigned i = 0; i < ee; i++) r = gf_xtime(r, m, poly);
    return r;
  endfunction

  // With c constant the selects below collapse to a fixed XOR matrix.
  function automatic logic [31:0] gf_mul_const(input logic [31:0] x, input logic [31:0] c,
                                               input int unsigned m, input logic [31:0] poly);
    logic [31:0] acc;
    logic [31:0] a;
    acc = 32'h0;
    a   = x & gf_mask(m);
    for (int unsigned i = 0; i < m; i++) begin
      if (((c >> i) & 32'h1) != 32'h0) acc = acc ^ a;
      a = gf_xtime(a, m, poly);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf_const_mult_column_seq_if.sv
// Load and beat handshake bundle for the constant-multiplier column.
interface gf_const_mult_column_seq_if #(
  parameter int unsigned M     = 13,
  parameter int unsigned NLANE = 16,
  parameter int unsigned CW    = 10
);
  logic               in_valid;
  logic               in_ready;
  logic [M-1:0]       in_b;
  logic [CW-1:0]      in_steps;
  logic               abort;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic [NLANE*M-1:0] out_data;

  modport master (
    output in_valid, in_b, in_steps, abort, out_ready,
    input  in_ready, out_valid, out_last, out_data
  );

  modport slave (
    input  in_valid, in_b, in_steps, abort, out_ready,
    output in_ready, out_valid, out_last, out_data
  );
endinterface

// File: rtl/gf_const_mul.sv
// y = x * alpha^EXP in GF(2^M); the constant is folded at elaboration, leaving only XORs.
module gf_const_mul
  import gf_pkg::*;
#(
  parameter int unsigned M    = GF_M,
  parameter logic [31:0] POLY = GF_POLY,
  parameter int unsigned EXP  = 1
) (
  input  logic [M-1:0] x,
  output logic [M-1:0] y
);
  localparam logic [31:0] C = gf_alpha_pow(EXP, M, POLY);

  assign y = M'(gf_mul_const(32'(x), C, M, POLY));
endmodule

// File: rtl/gf_const_mult_column_seq.sv
// Chien-style column: loads b*alpha^j into each lane, then streams beats while multiplying
// every lane in place by alpha^(j*STRIDE).
module gf_const_mult_column_seq
  import gf_pkg::*;
#(
  parameter int unsigned M      = GF_M,
  parameter logic [31:0] POLY   = GF_POLY,
  parameter int unsigned NLANE  = 16,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned CW     = 10
) (
  input logic                       clk,
  input logic                       rst_n,
  gf_const_mult_column_seq_if.slave bus
);

  col_state_e         r_state;
  col_state_e         w_state_nxt;
  logic [CW-1:0]      r_count;
  logic [NLANE*M-1:0] r_lanes;
  logic [NLANE*M-1:0] w_load_lanes;
  logic [NLANE*M-1:0] w_step_lanes;
  logic               w_load;
  logic               w_step;

  for (genvar j = 1; j <= NLANE; j++) begin : g_lane
    gf_const_mul #(.M(M), .POLY(POLY), .EXP(j)) u_load (
      .x (bus.in_b),
      .y (w_load_lanes[j*M-1 -: M])
    );
    gf_const_mul #(.M(M), .POLY(POLY), .EXP(j * STRIDE)) u_step (
      .x (r_lanes[j*M-1 -: M]),
      .y (w_step_lanes[j*M-1 -: M])
    );
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_step        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        // abort outranks a simultaneous load request
        if (!bus.abort && bus.in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        bus.out_valid = 1'b1;
        bus.out_last  = (r_count == CW'(1));
        if (bus.abort) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.out_ready) begin
          if (r_count == CW'(1)) w_state_nxt = ST_IDLE;
          else                   w_step      = 1'b1;
        end
      end
    endcase
  end

  assign bus.out_data = r_lanes;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      // NOTE: the lane bank is reset too, because out_data is driven straight from it
      // and must read zero out of reset.
      r_lanes <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_lanes <= w_load_lanes;
        r_count <= (bus.in_steps == '0) ? CW'(1) : bus.in_steps;
      end else if (w_step) begin
        r_lanes <= w_step_lanes;
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule
